mc_regfile_stage: RTL
=====================

// Module: mc_regfile_stage
// PURPOSE
//  Register-file stage of the multicycle MIPS datapath, directly downstream of the FSM controller.
//  Consumes RegWrite/RegDst/MemToReg and the instruction-register contents.
//  Performs write-back of ALUOut or memory data (MDR), and latches the A/B operand registers every cycle.
//  Also exposes a debug read port and a committed-write counter for the board display.
// PARAMETERS
//  WIDTH   32  datapath / register width in bits
//  NREG    32  number of architectural registers (r0 hardwired zero)
//  AW      5   register address width, log2(NREG)
//  CNTW    16  width of committed-write counter
// PORTS
//  CLK       in   1      clock, all state updates on rising edge
//  Reset     in   1      asynchronous, active-high
//  RegWrite  in   1      write-enable from controller (high only in MEMWB/RWB/IWB)
//  RegDst    in   1      1: dest = Instr[15:11] (rd); 0: dest = Instr[20:16] (rt)
//  MemToReg  in   1      1: write data = MemData; 0: write data = ALUOut
//  Instr     in   WIDTH  instruction register contents
//  ALUOut    in   WIDTH  ALUOut register value
//  MemData   in   WIDTH  memory data register (MDR) value
//  DbgAddr   in   AW     debug read address
//  A         out  WIDTH  operand register A = rf[Instr[25:21]], latched
//  B         out  WIDTH  operand register B = rf[Instr[20:16]], latched
//  DbgData   out  WIDTH  combinational rf[DbgAddr]; 0 when DbgAddr==0
//  WrCount   out  CNTW   number of committed register writes since reset
// BEHAVIOUR
//  Reset (async, any time incl. mid-instruction): all rf entries, A, B and WrCount go to 0 immediately.
//   Any write in flight is lost; DbgData follows rf, so it reads 0.
//  Write address WA = RegDst ? Instr[15:11] : Instr[20:16].
//  Write data WD = MemToReg ? MemData : ALUOut.
//  Commit: on posedge CLK with RegWrite==1 and WA!=0, rf[WA] <= WD and WrCount <= WrCount+1.
//   WrCount wraps modulo 2^CNTW.
//  RegWrite==0: no rf/WrCount change. RegDst, MemToReg, MemData and ALUOut may be X; they must not propagate.
//  RegWrite==1, WA==0: write discarded, WrCount unchanged; r0 always reads 0.
//  A/B: updated at every posedge CLK (no enable). A <= rf[Instr[25:21]], B <= rf[Instr[20:16]].
//   Latency 1 cycle from Instr to A/B.
//  Simultaneous write and read of the same register on one edge: A/B capture the PRE-write value (no bypass).
//   The controller FSM always interposes FETCH+DECODE after any write-back, so this cannot corrupt operands.
//  DbgData: purely combinational, reflects a commit in the same cycle after the edge; no effect on state.
//  RegWrite==X: treated as a testbench error; assert in simulation.
//  No stalls and no handshakes: the controller sequences all timing.
// STRUCTURE
//  Shared package mips_pkg:
//   - WIDTH/AW constants
//   - instruction field slices (RS_HI/LO=25:21, RT=20:16, RD=15:11)
//   - typedef reg_addr_t
//  Sub-module regfile_2r1w: NREG x WIDTH array, two read ports plus the debug read port, one write port.
//   Owns r0 masking and async clear.
//  Top level holds the WA/WD muxes, the A/B registers and WrCount.
// TESTING
//  1 Reset mid-run: write r5=0x1234, assert Reset between edges -> A, B, WrCount, DbgData(r5) all 0 without a clock edge.
//  2 R-type write-back: RegWrite=1, RegDst=1, MemToReg=0, Instr rd=8, ALUOut=0xDEADBEEF, one edge
//    -> DbgAddr=8 reads 0xDEADBEEF, WrCount=1.
//  3 LW write-back: RegWrite=1, RegDst=0, MemToReg=1, rt=9, MemData=0x0000_00FF
//    -> rf[9]=0xFF, then Instr rs=9, rt=8, next edge -> A=0xFF, B=0xDEADBEEF.
//  4 r0 protection: RegWrite=1, RegDst=1, rd=0, ALUOut=0x5 -> rf[0] reads 0, WrCount unchanged, A=0 when rs=0.
//  5 Same-edge hazard: rf[3]=7; write rf[3]=9 with rs=3 on the same edge -> A=7 after that edge, A=9 after the next.
//  6 Counter wrap + X guard: preload 2^CNTW-1 writes, one more commit -> WrCount=0;
//    RegWrite=0 with RegDst/MemToReg=X -> no rf change.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, instruction field positions and helpers for the multicycle MIPS datapath.
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CNTW  = 16;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef logic [AW-1:0] reg_addr_t;

  function automatic reg_addr_t rsField(input logic [WIDTH-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic reg_addr_t rtField(input logic [WIDTH-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

  function automatic reg_addr_t rdField(input logic [WIDTH-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: two operand read ports, one debug read port, one write port.
// Register 0 is never stored and always reads zero.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic [AW-1:0]    rdAddrA_i,
  output logic [WIDTH-1:0] rdDataA_o,
  input  logic [AW-1:0]    rdAddrB_i,
  output logic [WIDTH-1:0] rdDataB_o,
  input  logic [AW-1:0]    dbgAddr_i,
  output logic [WIDTH-1:0] dbgData_o
);

  logic [WIDTH-1:0] mem_q [NREG];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrEn_i && (wrAddr_i != '0)) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Masking r0 on the read side keeps it zero even if a write ever slipped through.
  assign rdDataA_o = (rdAddrA_i == '0) ? '0 : mem_q[rdAddrA_i];
  assign rdDataB_o = (rdAddrB_i == '0) ? '0 : mem_q[rdAddrB_i];
  assign dbgData_o = (dbgAddr_i == '0) ? '0 : mem_q[dbgAddr_i];

endmodule

// File: rtl/mc_regfile_stage.sv
// Register-file stage of the multicycle MIPS datapath: write-back muxing, A/B operand
// registers and a committed-write counter for the board display.
module mc_regfile_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             RegWrite,
  input  logic             RegDst,
  input  logic             MemToReg,
  input  logic [WIDTH-1:0] Instr,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] MemData,
  input  logic [AW-1:0]    DbgAddr,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DbgData,
  output logic [CNTW-1:0]  WrCount
);

  import mips_pkg::*;

  logic [AW-1:0]    wrAddr;
  logic [WIDTH-1:0] wrData;
  logic             commit;
  logic [WIDTH-1:0] rdDataA;
  logic [WIDTH-1:0] rdDataB;
  logic [WIDTH-1:0] A_q;
  logic [WIDTH-1:0] B_q;
  logic [CNTW-1:0]  WrCount_q;
  logic [CNTW-1:0]  WrCount_d;
  logic             unusedInstrBits;

  assign unusedInstrBits = ^{Instr[WIDTH-1:RS_HI+1], Instr[RD_LO-1:0]};

  // Gating on RegWrite first keeps X on RegDst/MemToReg/data out of the commit path.
  always_comb begin
    wrAddr = RegDst ? rdField(Instr) : rtField(Instr);
    wrData = MemToReg ? MemData : ALUOut;
    commit = 1'b0;
    if (RegWrite) begin
      commit = (wrAddr != '0);
    end
  end

  regfile_2r1w #(
    .WIDTH(WIDTH),
    .NREG (NREG),
    .AW   (AW)
  ) uRegfile (
    .CLK      (CLK),
    .Reset    (Reset),
    .wrEn_i   (commit),
    .wrAddr_i (wrAddr),
    .wrData_i (wrData),
    .rdAddrA_i(rsField(Instr)),
    .rdDataA_o(rdDataA),
    .rdAddrB_i(rtField(Instr)),
    .rdDataB_o(rdDataB),
    .dbgAddr_i(DbgAddr),
    .dbgData_o(DbgData)
  );

  always_comb begin
    WrCount_d = WrCount_q;
    if (commit) begin
      WrCount_d = WrCount_q + CNTW'(1);
    end
  end

  // A/B sample the array before this edge's write lands; the controller never reads back-to-back.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      A_q       <= '0;
      B_q       <= '0;
      WrCount_q <= '0;
    end else begin
      A_q       <= rdDataA;
      B_q       <= rdDataB;
      WrCount_q <= WrCount_d;
    end
  end

  assign A       = A_q;
  assign B       = B_q;
  assign WrCount = WrCount_q;

  assert property (@(posedge CLK) disable iff (Reset) !$isunknown(RegWrite));

endmodule
